// File: rtl/i2c_condition_generator_if.sv
// Command/status and line-level bundle for the I2C condition generator.
// Optional I2C_COND_STRETCH_EN adds the synchronised SCL readback i_scl_in.
interface i2c_condition_generator_if;
  logic       i_tick;
  logic       i_start;
  logic [1:0] i_cmd;
`ifdef I2C_COND_STRETCH_EN
  logic       i_scl_in;
`endif
  logic       o_sda;
  logic       o_scl;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

`ifdef I2C_COND_STRETCH_EN
  modport master (output i_tick, i_start, i_cmd, i_scl_in,
                  input  o_sda, o_scl, o_busy, o_done, o_err);
  modport slave  (input  i_tick, i_start, i_cmd, i_scl_in,
                  output o_sda, o_scl, o_busy, o_done, o_err);
`else
  modport master (output i_tick, i_start, i_cmd,
                  input  o_sda, o_scl, o_busy, o_done, o_err);
  modport slave  (input  i_tick, i_start, i_cmd,
                  output o_sda, o_scl, o_busy, o_done, o_err);
`endif
endinterface

// File: rtl/i2c_condition_generator.sv
// START / REPEATED START / STOP generator with registered SDA/SCL levels.
// Define I2C_COND_STRETCH_EN to honour SCL clock stretching with a timeout abort.
module i2c_condition_generator #(
  parameter int PHASE_TICKS     = 1,
  parameter int STRETCH_TIMEOUT = 1023
) (
  input logic i_clk,
  input logic i_rst,
  i2c_condition_generator_if.slave bus
);

  if (PHASE_TICKS < 1 || PHASE_TICKS > 255) begin : g_bad_phase_ticks
    $error("PHASE_TICKS out of range 1..255");
  end
  if (STRETCH_TIMEOUT < 1 || STRETCH_TIMEOUT > 65535) begin : g_bad_timeout
    $error("STRETCH_TIMEOUT out of range 1..65535");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam logic [1:0] CMD_START   = 2'b00;
  localparam logic [1:0] CMD_RSTART  = 2'b01;
  localparam logic [1:0] CMD_RESERVED = 2'b11;
  localparam logic [7:0] TICK_LAST   = 8'(PHASE_TICKS - 1);

  state_t     state, state_n;
  logic [1:0] phase, phase_n;
  logic [7:0] tick_cnt, tick_cnt_n;
  logic [1:0] cmd, cmd_n;
  logic       sda, sda_n, scl, scl_n;
  logic       busy_n, done_n, err_n;
  logic       tick_ok;
  logic [1:0] last_phase;

  // Line levels {sda, scl} for each phase of each condition.
  function automatic logic [1:0] phase_levels(input logic [1:0] c, input logic [1:0] p);
    logic [1:0] lv;
    lv = 2'b11;
    case (c)
      CMD_START:  case (p)
                    2'd0:    lv = 2'b11;
                    2'd1:    lv = 2'b01;
                    default: lv = 2'b00;
                  endcase
      CMD_RSTART: case (p)
                    2'd0:    lv = 2'b10;
                    2'd1:    lv = 2'b11;
                    2'd2:    lv = 2'b01;
                    default: lv = 2'b00;
                  endcase
      default:    case (p)
                    2'd0:    lv = 2'b00;
                    2'd1:    lv = 2'b01;
                    default: lv = 2'b11;
                  endcase
    endcase
    return lv;
  endfunction

`ifdef I2C_COND_STRETCH_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(STRETCH_TIMEOUT - 1);
  logic [15:0] to_cnt, to_cnt_n;
  logic        stretched;
  assign stretched = scl && !bus.i_scl_in;
`endif

  assign last_phase = (cmd == CMD_RSTART) ? 2'd3 : 2'd2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      phase      <= 2'd0;
      tick_cnt   <= 8'd0;
      cmd        <= CMD_START;
      sda        <= 1'b1;
      scl        <= 1'b1;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_err  <= 1'b0;
`ifdef I2C_COND_STRETCH_EN
      to_cnt     <= 16'd0;
`endif
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      tick_cnt   <= tick_cnt_n;
      cmd        <= cmd_n;
      sda        <= sda_n;
      scl        <= scl_n;
      bus.o_busy <= busy_n;
      bus.o_done <= done_n;
      bus.o_err  <= err_n;
`ifdef I2C_COND_STRETCH_EN
      to_cnt     <= to_cnt_n;
`endif
    end
  end

  assign bus.o_sda = sda;
  assign bus.o_scl = scl;

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    tick_cnt_n = tick_cnt;
    cmd_n      = cmd;
    sda_n      = sda;
    scl_n      = scl;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    tick_ok    = bus.i_tick;
`ifdef I2C_COND_STRETCH_EN
    to_cnt_n   = to_cnt;
    tick_ok    = bus.i_tick && !stretched;
`endif

    case (state)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_cmd == CMD_RESERVED) begin
            state_n = ERR;
            err_n   = 1'b1;
          end else begin
            state_n        = RUN;
            cmd_n          = bus.i_cmd;
            phase_n        = 2'd0;
            tick_cnt_n     = 8'd0;
            busy_n         = 1'b1;
            {sda_n, scl_n} = phase_levels(bus.i_cmd, 2'd0);
`ifdef I2C_COND_STRETCH_EN
            to_cnt_n       = 16'd0;
`endif
          end
        end
      end

      RUN: begin
        busy_n = 1'b1;
        if (tick_ok) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = 8'd0;
`ifdef I2C_COND_STRETCH_EN
            to_cnt_n   = 16'd0;
`endif
            if (phase == last_phase) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              phase_n        = phase + 2'd1;
              {sda_n, scl_n} = phase_levels(cmd, phase + 2'd1);
            end
          end else begin
            tick_cnt_n = tick_cnt + 8'd1;
          end
        end
`ifdef I2C_COND_STRETCH_EN
        // A slave holding SCL low past the budget aborts and releases the bus.
        if (bus.i_tick && stretched) begin
          if (to_cnt == TIMEOUT_LAST) begin
            state_n  = ERR;
            err_n    = 1'b1;
            busy_n   = 1'b0;
            sda_n    = 1'b1;
            scl_n    = 1'b1;
            to_cnt_n = 16'd0;
          end else begin
            to_cnt_n = to_cnt + 16'd1;
          end
        end
`endif
      end

      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/i2c_condition_generator.md
Name: i2c_condition_generator

Overview:
Parametrised bus-condition engine for the I2C master datapath; generates START, REPEATED START and STOP conditions on SCL/SDA from a single command interface. Each condition is a fixed sequence of phases, and each phase lasts PHASE_TICKS quarter-bit ticks from the shared baud tick generator. Outputs are registered line levels (1 = release, 0 = pull low) feeding the open-drain pad drivers. Replaces the single-purpose stop generator, adding command selection, programmable phase length, busy/error status and bus-state hold between commands.

Parameters:
PHASE_TICKS, 1, number of i_tick pulses per phase; legal 1..255.
STRETCH_TIMEOUT, 1023, i_tick pulses allowed for a stretched SCL-high phase before abort; used only with I2C_COND_STRETCH_EN; legal 1..65535.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_tick  in  1  single-cycle phase-timing strobe
i_start  in  1  command request, sampled only in IDLE
i_cmd  in  2  00 START, 01 REPEATED START, 10 STOP, 11 reserved
i_scl_in  in  1  synchronised SCL pad readback (present only with I2C_COND_STRETCH_EN)
o_sda  out  1  SDA drive level (registered)
o_scl  out  1  SCL drive level (registered)
o_busy  out  1  high from the cycle after acceptance through the DONE cycle
o_done  out  1  one-cycle pulse when the condition completes
o_err  out  1  one-cycle pulse on reserved command or stretch timeout

Behaviour:
- Reset: state IDLE; o_sda=1, o_scl=1, o_busy=0, o_done=0, o_err=0; phase and tick counters 0. Reset mid-sequence aborts immediately and releases both lines on the next edge.
- States: IDLE, RUN (phase index 0..3), DONE, ERR.
- Acceptance: in IDLE, i_start=1 and i_cmd!=11 in cycle N -> cycle N+1 in RUN phase 0, o_busy=1, outputs = phase 0 levels. i_tick in cycle N is not counted.
- i_cmd=11 in IDLE with i_start -> cycle N+1 in ERR: o_err=1 for one cycle, line levels unchanged, then IDLE. o_busy stays 0.
- i_start while not IDLE is ignored; no queuing.
- Phase levels (sda,scl):
  - START: P0 (1,1), P1 (0,1), P2 (0,0).
  - REPEATED START: P0 (1,0), P1 (1,1), P2 (0,1), P3 (0,0).
  - STOP: P0 (0,0), P1 (0,1), P2 (1,1).
- Phase advance: the tick counter increments on each i_tick in RUN. On the i_tick that makes the count equal PHASE_TICKS, the counter clears and the phase index advances, with new levels on the next cycle.
- Completion: the final tick of the last phase moves to DONE (o_done=1, o_busy=1 for one cycle), then IDLE.
- Line levels are held through DONE and IDLE until the next command or reset. After START the bus holds (0,0); after STOP it holds (1,1).
- Latency with PHASE_TICKS=1 and i_tick continuously high: START/STOP give o_done at N+4; REPEATED START gives o_done at N+5.
- No check of bus state before a command. The caller is responsible for legal ordering.

Optional Feature:
I2C_COND_STRETCH_EN
- Defined:
  - i_scl_in exists.
  - In any phase driving o_scl=1, ticks count toward PHASE_TICKS only while i_scl_in=1.
  - While i_scl_in=0, a separate timeout counter counts i_tick. Reaching STRETCH_TIMEOUT enters ERR: o_err=1 for one cycle, o_sda=1, o_scl=1, o_busy drops, no o_done, then IDLE.
  - The timeout counter clears on phase advance.
- Undefined:
  - No i_scl_in port.
  - Phases are purely tick-counted.
  - o_err fires only for the reserved command.

Test Plan:
1. Reset, PHASE_TICKS=1, tick every cycle, i_start with cmd=00 at cycle 0 -> (sda,scl) = (1,1),(0,1),(0,0) on cycles 1-3; o_done=1 at cycle 4; lines hold (0,0) afterward.
2. PHASE_TICKS=4, tick every 3rd cycle, cmd=10 -> each phase lasts 12 cycles; final (1,1); exactly one o_done pulse; o_busy high 37 cycles.
3. After START, cmd=01 -> (1,0),(1,1),(0,1),(0,0); o_done at acceptance+5.
4. cmd=11 -> o_err=1 for one cycle at N+1; o_busy, o_done stay 0; lines unchanged. Second i_start during a busy STOP -> ignored, single o_done.
5. Assert i_rst mid-phase 1 of STOP -> next cycle (1,1), o_busy=0, no o_done; a new START then runs normally.
6. With I2C_COND_STRETCH_EN, STRETCH_TIMEOUT=8: hold i_scl_in=0 during STOP P1 -> phase stalls, o_err pulse after 8 ticks, lines (1,1), no o_done. Release after 3 ticks -> completes normally.
